l2_writeback_buffer: RTL and testbench

Four-entry dirty-line writeback buffer between the L2 cache controller and physical memory. The L2 controller pushes an evicted 256-bit line and its address in one cycle and continues without waiting for memory. The buffer drains entries in FIFO order to physical memory over the pmem write handshake. It also answers combinational lookups, so an L2 miss on a line still in the buffer is served from the buffer rather than from stale memory.

---
 rtl/l2_writeback_buffer.sv | 117 +++++++++++
 tb/tb_l2_writeback_buffer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_writeback_buffer.sv
// rtl/l2_writeback_buffer.sv - dirty-line writeback buffer between L2 and physical memory
// FIFO drain over the pmem handshake, in-place coalescing of re-evicted lines, newest-match lookup.
module l2_writeback_buffer #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [31:0]      push_addr,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  output logic             empty,
  input  logic [31:0]      lookup_addr,
  output logic             lookup_hit,
  output logic [WIDTH-1:0] lookup_data,
  output logic             pmem_write,
  output logic [31:0]      pmem_address,
  output logic [WIDTH-1:0] pmem_wdata,
  input  logic             pmem_resp
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, WRITE} state_t;
  state_t state, state_n;

  logic [DEPTH-1:0] valid;
  logic [26:0]      tag  [DEPTH];
  logic [WIDTH-1:0] line [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, coal_idx, look_idx, scan_idx;
  logic [AW:0]      count;
  logic             can_push, coal_hit, alloc, pop;
  logic             unused_offsets;

  assign unused_offsets = ^{push_addr[4:0], lookup_addr[4:0]};

  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0) && (state == IDLE);
  assign can_push = push && !full;
  assign pop      = (state == WRITE) && pmem_resp;

  // The head being written must not change under memory, so it is excluded from coalescing.
  always_comb begin
    coal_hit = 1'b0;
    coal_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && tag[i] == push_addr[31:5] &&
          !(state == WRITE && AW'(i) == rd_ptr)) begin
        coal_hit = 1'b1;
        coal_idx = AW'(i);
      end
    end
  end

  assign alloc = can_push && !coal_hit;

  // Scan oldest to newest so the last match found is the newest copy.
  always_comb begin
    lookup_hit = 1'b0;
    look_idx   = '0;
    scan_idx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = rd_ptr + AW'(k);
      if (valid[scan_idx] && tag[scan_idx] == lookup_addr[31:5]) begin
        lookup_hit = 1'b1;
        look_idx   = scan_idx;
      end
    end
  end

  assign lookup_data  = lookup_hit ? line[look_idx] : '0;
  assign pmem_address = {tag[rd_ptr], 5'b0};
  assign pmem_wdata   = line[rd_ptr];

  always_comb begin
    state_n    = state;
    pmem_write = 1'b0;
    case (state)
      IDLE:  if (count != '0) state_n = WRITE;
      WRITE: begin
        pmem_write = 1'b1;
        if (pmem_resp) state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      valid  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      state <= state_n;
      if (pop) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + 1'b1;
      end
      if (alloc) begin
        valid[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      count <= count + {AW'(0), alloc} - {AW'(0), pop};
    end
  end

  always_ff @(posedge clk) begin
    if (alloc) begin
      tag[wr_ptr]  <= push_addr[31:5];
      line[wr_ptr] <= push_data;
    end else if (can_push && coal_hit) begin
      line[coal_idx] <= push_data;
    end
  end
endmodule

// File: tb/tb_l2_writeback_buffer.sv
// tb/tb_l2_writeback_buffer.sv - self-checking bench for l2_writeback_buffer
module tb_l2_writeback_buffer;
  localparam int W = 256;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          rst, push, pmem_resp;
  logic [31:0]   push_addr, lookup_addr, pmem_address;
  logic [W-1:0]  push_data, lookup_data, pmem_wdata;
  logic          full, empty, lookup_hit, pmem_write;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [26:0]  a;
    logic [W-1:0] d;
  } ent_t;
  ent_t q[$];
  bit   m_wr;

  l2_writeback_buffer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .push(push), .push_addr(push_addr), .push_data(push_data),
    .full(full), .empty(empty),
    .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .lookup_data(lookup_data),
    .pmem_write(pmem_write), .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  // Queue model: oldest line at the front, flag for a front line currently being written.
  function automatic void model_tick();
    int sz;
    int hit;
    bit popped;
    if (rst) begin
      q.delete();
      m_wr = 0;
      return;
    end
    sz = q.size();
    popped = m_wr && pmem_resp;
    if (push && sz < D) begin
      hit = -1;
      for (int i = 0; i < sz; i++)
        if (q[i].a == push_addr[31:5] && !(i == 0 && m_wr)) hit = i;
      if (hit >= 0) q[hit].d = push_data;
      else q.push_back('{push_addr[31:5], push_data});
    end
    if (popped) begin
      q.delete(0);
      m_wr = 0;
    end else if (!m_wr && sz > 0) begin
      m_wr = 1;
    end
  endfunction

  function automatic logic [W:0] ref_lookup(input logic [31:0] la);
    ref_lookup = '0;
    foreach (q[i]) if (q[i].a == la[31:5]) ref_lookup = {1'b1, q[i].d};
  endfunction

  function automatic logic [W-1:0] rand_line();
    for (int i = 0; i < W/32; i++) rand_line[i*32 +: 32] = $urandom();
  endfunction

  task automatic tick();
    @(posedge clk);
    model_tick();
    @(negedge clk);
    push = 1'b0;
    pmem_resp = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    lookup_addr = 32'h0000_1040;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
    checks++; if (pmem_write !== 1'b0) begin errors++; $display("FAIL reset_pmem_write: got %b want 0", pmem_write); end
    checks++; if (lookup_hit !== 1'b0 || lookup_data !== '0) begin
      errors++; $display("FAIL reset_lookup: hit %b data %h want 0/0", lookup_hit, lookup_data);
    end
  endtask

  task automatic test_single();
    logic [W-1:0] pat = {(W/8){8'hA5}};
    push = 1'b1; push_addr = 32'h0000_1040; push_data = pat;
    tick();
    checks++; if (full !== 1'b0 || empty !== 1'b0 || pmem_write !== 1'b0) begin
      errors++; $display("FAIL single_n1: full %b empty %b pw %b want 0 0 0", full, empty, pmem_write);
    end
    tick();
    for (int c = 0; c < 3; c++) begin
      checks++; if (pmem_write !== 1'b1 || pmem_address !== 32'h0000_1040 || pmem_wdata !== pat) begin
        errors++; $display("FAIL single_write[%0d]: pw %b addr %h data %h", c, pmem_write, pmem_address, pmem_wdata);
      end
      if (c == 2) pmem_resp = 1'b1;
      tick();
    end
    checks++; if (pmem_write !== 1'b0 || empty !== 1'b1) begin
      errors++; $display("FAIL single_done: pw %b empty %b want 0 1", pmem_write, empty);
    end
  endtask

  task automatic test_fill_and_wrap();
    logic [31:0]  ea[6];
    logic [W-1:0] ed[6];
    int t;
    for (int i = 0; i < 6; i++) begin
      ea[i] = 32'h0000_2000 + 32'(i) * 32'h20;
      ed[i] = rand_line();
    end
    for (int i = 0; i < 4; i++) begin
      push = 1'b1; push_addr = ea[i]; push_data = ed[i];
      tick();
    end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full: got %b want 1", full); end
    push = 1'b1; push_addr = 32'h0000_2080; push_data = rand_line();
    tick();
    lookup_addr = 32'h0000_2080;
    #1;
    checks++; if (full !== 1'b1 || lookup_hit !== 1'b0) begin
      errors++; $display("FAIL fill_fifth_ignored: full %b hit %b want 1 0", full, lookup_hit);
    end
    for (int n = 0; n < 6; n++) begin
      if (n == 4) begin
        for (int i = 4; i < 6; i++) begin
          push = 1'b1; push_addr = ea[i]; push_data = ed[i];
          tick();
        end
      end
      t = 0;
      while (pmem_write !== 1'b1 && t < 20) begin tick(); t++; end
      checks++; if (pmem_write !== 1'b1 || pmem_address !== ea[n] || pmem_wdata !== ed[n]) begin
        errors++; $display("FAIL fill_drain[%0d]: pw %b addr %h want %h", n, pmem_write, pmem_address, ea[n]);
      end
      pmem_resp = 1'b1;
      tick();
      checks++; if (pmem_write !== 1'b0) begin
        errors++; $display("FAIL fill_deassert[%0d]: pw %b want 0", n, pmem_write);
      end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fill_empty: got %b want 1", empty); end
  endtask

  task automatic test_coalesce();
    logic [W-1:0] x = rand_line(), d1 = rand_line(), d2 = rand_line();
    logic [31:0]  ea[2] = '{32'h0000_0400, 32'h0000_0100};
    logic [W-1:0] ed[2];
    int t;
    ed[0] = x; ed[1] = d2;
    push = 1'b1; push_addr = 32'h0000_0400; push_data = x;
    tick();
    tick();
    push = 1'b1; push_addr = 32'h0000_0100; push_data = d1;
    tick();
    push = 1'b1; push_addr = 32'h0000_0100; push_data = d2;
    tick();
    lookup_addr = 32'h0000_0100;
    #1;
    checks++; if (lookup_hit !== 1'b1 || lookup_data !== d2) begin
      errors++; $display("FAIL coalesce_lookup: hit %b data %h want 1 %h", lookup_hit, lookup_data, d2);
    end
    for (int n = 0; n < 2; n++) begin
      t = 0;
      while (pmem_write !== 1'b1 && t < 20) begin tick(); t++; end
      checks++; if (pmem_write !== 1'b1 || pmem_address !== ea[n] || pmem_wdata !== ed[n]) begin
        errors++; $display("FAIL coalesce_drain[%0d]: pw %b addr %h data %h", n, pmem_write, pmem_address, pmem_wdata);
      end
      pmem_resp = 1'b1;
      tick();
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL coalesce_single_entry: empty %b want 1", empty); end
  endtask

  task automatic test_inflight_alloc();
    logic [W-1:0] d1 = rand_line(), d2 = rand_line();
    logic [W-1:0] ed[2];
    int t;
    ed[0] = d1; ed[1] = d2;
    push = 1'b1; push_addr = 32'h0000_0200; push_data = d1;
    tick();
    tick();
    checks++; if (pmem_write !== 1'b1 || pmem_address !== 32'h0000_0200) begin
      errors++; $display("FAIL inflight_start: pw %b addr %h want 1 00000200", pmem_write, pmem_address);
    end
    push = 1'b1; push_addr = 32'h0000_0200; push_data = d2;
    tick();
    lookup_addr = 32'h0000_0200;
    #1;
    checks++; if (lookup_hit !== 1'b1 || lookup_data !== d2) begin
      errors++; $display("FAIL inflight_lookup: hit %b data %h want 1 %h", lookup_hit, lookup_data, d2);
    end
    for (int n = 0; n < 2; n++) begin
      t = 0;
      while (pmem_write !== 1'b1 && t < 20) begin tick(); t++; end
      checks++; if (pmem_write !== 1'b1 || pmem_address !== 32'h0000_0200 || pmem_wdata !== ed[n]) begin
        errors++; $display("FAIL inflight_drain[%0d]: pw %b data %h want %h", n, pmem_write, pmem_wdata, ed[n]);
      end
      pmem_resp = 1'b1;
      tick();
    end
  endtask

  task automatic test_lookup_offsets();
    logic [W-1:0] d3 = rand_line();
    int t;
    push = 1'b1; push_addr = 32'h0000_0200; push_data = d3;
    tick();
    lookup_addr = 32'h0000_0300;
    #1;
    checks++; if (lookup_hit !== 1'b0 || lookup_data !== '0) begin
      errors++; $display("FAIL lookup_absent: hit %b data %h want 0 0", lookup_hit, lookup_data);
    end
    lookup_addr = 32'h0000_021F;
    #1;
    checks++; if (lookup_hit !== 1'b1 || lookup_data !== d3) begin
      errors++; $display("FAIL lookup_offset: hit %b data %h want 1 %h", lookup_hit, lookup_data, d3);
    end
    t = 0;
    while (pmem_write !== 1'b1 && t < 20) begin tick(); t++; end
    pmem_resp = 1'b1;
    tick();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL lookup_drained: empty %b want 1", empty); end
  endtask

  task automatic test_reset_midwrite();
    for (int i = 0; i < 3; i++) begin
      push = 1'b1; push_addr = 32'h0000_0500 + 32'(i) * 32'h20; push_data = rand_line();
      tick();
    end
    checks++; if (pmem_write !== 1'b1) begin errors++; $display("FAIL midrst_writing: pw %b want 1", pmem_write); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (pmem_write !== 1'b0 || empty !== 1'b1 || full !== 1'b0) begin
      errors++; $display("FAIL midrst_after: pw %b empty %b full %b want 0 1 0", pmem_write, empty, full);
    end
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++; if (pmem_write !== 1'b0) begin errors++; $display("FAIL midrst_quiet[%0d]: pw %b want 0", c, pmem_write); end
    end
  endtask

  task automatic test_random();
    logic [W:0] r;
    for (int c = 0; c < 600; c++) begin
      push        = ($urandom_range(9) < 4) && (q.size() < D);
      push_addr   = 32'h0000_8000 + (32'($urandom_range(5)) << 5) + 32'($urandom_range(31));
      push_data   = rand_line();
      pmem_resp   = ($urandom_range(9) < 3);
      lookup_addr = 32'h0000_8000 + (32'($urandom_range(6)) << 5) + 32'($urandom_range(31));
      #1;
      r = ref_lookup(lookup_addr);
      checks++; if (full !== (q.size() == D) || empty !== (q.size() == 0 && !m_wr) || pmem_write !== m_wr) begin
        errors++; $display("FAIL rand_status[%0d]: full %b empty %b pw %b model size %0d writing %b", c, full, empty, pmem_write, q.size(), m_wr);
      end
      checks++; if ({lookup_hit, lookup_data} !== r) begin
        errors++; $display("FAIL rand_lookup[%0d]: hit %b data %h want %b %h", c, lookup_hit, lookup_data, r[W], r[W-1:0]);
      end
      if (m_wr) begin
        checks++; if (pmem_address !== {q[0].a, 5'b0} || pmem_wdata !== q[0].d) begin
          errors++; $display("FAIL rand_head[%0d]: addr %h want %h", c, pmem_address, {q[0].a, 5'b0});
        end
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; push = 1'b0; pmem_resp = 1'b0;
    push_addr = '0; push_data = '0; lookup_addr = '0;
    m_wr = 0;
    @(negedge clk);
    test_reset();
    test_single();
    test_fill_and_wrap();
    test_coalesce();
    test_inflight_alloc();
    test_lookup_offsets();
    test_reset_midwrite();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
